axis_sync_pkt_fifo: RTL

Single-clock AXI4-Stream FIFO that generalises the team's AXIS data FIFO. It adds a full valid/ready handshake, TLAST/TKEEP sideband storage, a selectable store-and-forward packet mode, and occupancy/status outputs. It sits between AXIS producers and consumers that share one clock domain, for example in front of packet parsers that must not see partial frames.

---
 rtl/axis_sync_pkt_fifo.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/axis_sync_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_sync_pkt_fifo
// Purpose  : Single-clock AXI4-Stream FIFO with TLAST/TKEEP storage,
//            first-word fall-through output, optional store-and-forward
//            packet mode with forced release on oversize packets, and
//            occupancy/status outputs.
// Ports    : axis_clk / axis_rst     clock, async active-high reset
//            s_axis_*                slave stream (tvalid/tready/tdata/tkeep/tlast)
//            m_axis_*                master stream (tvalid/tready/tdata/tkeep/tlast)
//            data_count              beats currently stored
//            pkt_count               tlast beats currently stored
//            almost_full             data_count >= AF_THRESH
//            oversize                one-cycle pulse on forced release
// Revision : 1.0 - initial release
// ============================================================================
module axis_sync_pkt_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0,
    parameter int AF_THRESH   = DEPTH - 2
) (
    input  logic                         axis_clk,
    input  logic                         axis_rst,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]      s_axis_tkeep,
    input  logic                         s_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]      m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic [$clog2(DEPTH+1)-1:0]   data_count,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
    output logic                         almost_full,
    output logic                         oversize
);

    localparam int c_KEEP_W  = DATA_WIDTH / 8;
    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = $clog2(DEPTH + 1);
    localparam int c_ENTRY_W = 1 + c_KEEP_W + DATA_WIDTH;

    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_CNT   = c_CNT_W'(AF_THRESH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    // Entry layout: {tlast, tkeep, tdata}
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_data_count;
    logic [c_CNT_W-1:0]   r_pkt_count;

    logic [c_ENTRY_W-1:0] w_rd_entry;
    logic                 w_s_ready;
    logic                 w_m_valid;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_wr_last;
    logic                 w_rd_last;
    logic                 w_oversize;

    assign w_s_ready  = (r_data_count != c_FULL_CNT);
    assign w_wr       = s_axis_tvalid && w_s_ready;
    assign w_rd       = w_m_valid && m_axis_tready;
    assign w_rd_entry = r_mem[r_rd_ptr];
    assign w_wr_last  = w_wr && s_axis_tlast;
    assign w_rd_last  = w_rd && w_rd_entry[c_ENTRY_W-1];

    // Storage is deliberately not reset; contents are qualified by the counters.
    always_ff @(posedge axis_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_data_count <= '0;
            r_pkt_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            if (w_wr && !w_rd) begin
                r_data_count <= r_data_count + c_CNT_ONE;
            end else if (!w_wr && w_rd) begin
                r_data_count <= r_data_count - c_CNT_ONE;
            end

            if (w_wr_last && !w_rd_last) begin
                r_pkt_count <= r_pkt_count + c_CNT_ONE;
            end else if (!w_wr_last && w_rd_last) begin
                r_pkt_count <= r_pkt_count - c_CNT_ONE;
            end
        end
    end

    generate
        if (PACKET_MODE != 0) begin : g_packet
            logic r_release;
            logic r_oversize;
            logic w_force;

            // A full FIFO holding no complete packet can never make progress
            // on its own, so the partial packet is released to drain.
            assign w_force = (r_data_count == c_FULL_CNT) && (r_pkt_count == '0) && !r_release;

            always_ff @(posedge axis_clk or posedge axis_rst) begin
                if (axis_rst) begin
                    r_release  <= 1'b0;
                    r_oversize <= 1'b0;
                end else begin
                    r_oversize <= w_force;
                    if (w_force) begin
                        r_release <= 1'b1;
                    end else if (w_rd_last) begin
                        r_release <= 1'b0;
                    end
                end
            end

            // While released, beats drain as in cut-through, so valid also
            // needs data present (the release can outlive the stored beats).
            assign w_m_valid  = (r_pkt_count != '0) || (r_release && (r_data_count != '0));
            assign w_oversize = r_oversize;
        end else begin : g_cut
            assign w_m_valid  = (r_data_count != '0);
            assign w_oversize = 1'b0;
        end
    endgenerate

    assign s_axis_tready = w_s_ready;
    assign m_axis_tvalid = w_m_valid;
    assign m_axis_tlast  = w_rd_entry[c_ENTRY_W-1];
    assign m_axis_tkeep  = w_rd_entry[c_ENTRY_W-2 -: c_KEEP_W];
    assign m_axis_tdata  = w_rd_entry[DATA_WIDTH-1:0];
    assign data_count    = r_data_count;
    assign pkt_count     = r_pkt_count;
    assign almost_full   = (r_data_count >= c_AF_CNT);
    assign oversize      = w_oversize;

endmodule
`default_nettype wire
